down_counter_sched: RTL and testbench

- Round-robin scheduler that shares a single 16-bit down-counter timer among NUM_REQ requesters.
- Each requester presents a load value and holds a request.
- The block grants one requester and loads the counter, then counts down to zero and pulses that requester's done line.
- Sits between several client FSMs and the shared timer resource in the simple_registers/counters family.

---
 rtl/down_counter_sched.sv | 132 +++++++++++++
 tb/tb_down_counter_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sched.sv
// down_counter_sched
//   Round-robin scheduler sharing one down-counter timer among NUM_REQ
//   requesters. The winner of arbitration owns the counter, which is loaded
//   with that requester's load value and counted down to zero; the owner
//   then sees a single-cycle done pulse. Dropping req mid-count abandons
//   the timer without a done pulse.
//
//   Ports
//     clock0    : clock, all state on rising edge
//     reset     : synchronous active-low reset
//     req       : per-requester level request
//     load_val  : requester i start value on [i*WIDTH +: WIDTH]
//     grant     : one-hot owner of the counter (registered), 0 when idle
//     done      : one-hot single-cycle completion pulse to the owner
//     busy      : high whenever the scheduler is not idle
//     count     : current counter value
module down_counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic                       clock0,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   load_val,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [WIDTH-1:0]           count
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state_q;
    logic [IDXW-1:0]    owner_q;
    logic [IDXW-1:0]    last_q;
    logic [WIDTH-1:0]   count_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;

    // Unpacked view of the flat load bus, one entry per requester.
    logic [WIDTH-1:0] ld [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ld
        assign ld[gi] = load_val[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: first set req bit scanning upward from last+1 with
    // wrap, so the previous owner is considered last.
    logic               win_vld;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW-1:0]    cand;
    logic [NUM_REQ-1:0] win_oh;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        win_oh  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDXW'((int'(last_q) + k) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        if (win_vld) win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clock0) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDXW'(NUM_REQ - 1);
            count_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant_q <= win_oh;
                        owner_q <= win_idx;
                        count_q <= ld[win_idx];
                        // A zero load completes in the first granted cycle.
                        if (ld[win_idx] == '0) begin
                            state_q <= DONE;
                            done_q  <= win_oh;
                        end else begin
                            state_q <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (!req[owner_q]) begin
                        // Abandon: release the timer silently.
                        state_q <= IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                        last_q  <= owner_q;
                    end else begin
                        // count is always >= 1 here, so this never wraps.
                        count_q <= count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_q <= DONE;
                            done_q  <= grant_q;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    count_q <= '0;
                    last_q  <= owner_q;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign count = count_q;

endmodule

// File: tb/tb_down_counter_sched.sv
module tb_down_counter_sched;

    localparam int N = 4;
    localparam int W = 16;

    logic             clock0 = 1'b0;
    logic             reset  = 1'b0;
    logic [N-1:0]     req    = '0;
    logic [N*W-1:0]   load_val = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic             busy;
    logic [W-1:0]     count;

    down_counter_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clock0   (clock0),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    always #5 clock0 = ~clock0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [63:0] ld;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [15:0] c;
    } vec_t;

    typedef struct {
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [15:0] c;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] gq[$];

    function automatic logic [63:0] ldv(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs,
    // then pop and compare once the edge has happened.
    task automatic step(input logic r, input logic [3:0] rq, input logic [63:0] ld,
                        input logic [3:0] g, input logic [3:0] d, input logic b,
                        input logic [15:0] c, input string nm);
        exp_t e;
        reset = r; req = rq; load_val = ld;
        e.g = g; e.d = d; e.b = b; e.c = c;
        sb.push_back(e);
        @(posedge clock0); #1;
        e = sb.pop_front();
        chk({nm, ".grant"}, 32'(grant), 32'(e.g));
        chk({nm, ".done"},  32'(done),  32'(e.d));
        chk({nm, ".busy"},  32'(busy),  32'(e.b));
        chk({nm, ".count"}, 32'(count), 32'(e.c));
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0;
        repeat (2) @(posedge clock0);
        #1;
        reset = 1'b1;
    endtask

    // Watch the grant stream; each new grant is popped from gq and compared.
    // Each turn must carry exactly one done pulse, coincident with grant.
    task automatic watch(input string nm, input int budget, input bit drop_mode);
        logic [3:0] prevg = '0;
        logic [3:0] restore = '0;
        int         turn_dones = 0;
        int         n = 0;
        while (gq.size() != 0 && n < budget) begin
            @(posedge clock0); #1;
            n++;
            if (restore != 0) begin
                req = req | restore;
                restore = '0;
            end
            if (grant != 0 && prevg == 0) begin
                logic [3:0] eg;
                eg = gq.pop_front();
                chk({nm, ".grant"}, 32'(grant), 32'(eg));
                turn_dones = 0;
            end
            if (grant == 0 && prevg != 0)
                chk({nm, ".dones_per_turn"}, turn_dones, 1);
            if (done != 0) begin
                turn_dones++;
                chk({nm, ".done_eq_grant"}, 32'(done), 32'(grant));
                chk({nm, ".done_count0"}, 32'(count), 0);
                if (drop_mode) begin
                    req = req & ~done;
                    restore = done;
                end
            end
            prevg = grant;
        end
        chk({nm, ".all_grants_seen"}, gq.size(), 0);
        gq.delete();
    endtask

    task automatic wait_count(input logic [15:0] v, input string nm);
        bit found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(posedge clock0); #1;
            if (done != 0) chk({nm, ".no_done"}, 32'(done), 0);
            if (count == v) found = 1'b1;
        end
        chk({nm, ".reached"}, 32'(found), 1);
    endtask

    vec_t tv[9];

    initial begin
        tv[0] = '{1'b0, 4'h0, 64'h0,               4'h0, 4'h0, 1'b0, 16'h0};
        tv[1] = '{1'b0, 4'h0, 64'h0,               4'h0, 4'h0, 1'b0, 16'h0};
        tv[2] = '{1'b1, 4'h1, ldv(16'd3, 0, 0, 0), 4'h1, 4'h0, 1'b1, 16'd3};
        // load value changing after grant must not disturb the count
        tv[3] = '{1'b1, 4'h1, ldv(16'd7, 0, 0, 0), 4'h1, 4'h0, 1'b1, 16'd2};
        tv[4] = '{1'b1, 4'h1, ldv(16'd7, 0, 0, 0), 4'h1, 4'h0, 1'b1, 16'd1};
        tv[5] = '{1'b1, 4'h1, ldv(16'd7, 0, 0, 0), 4'h1, 4'h1, 1'b1, 16'd0};
        tv[6] = '{1'b1, 4'h0, 64'h0,               4'h0, 4'h0, 1'b0, 16'd0};
        // zero load: grant and done together, busy for one cycle
        tv[7] = '{1'b1, 4'h4, 64'h0,               4'h4, 4'h4, 1'b1, 16'd0};
        tv[8] = '{1'b1, 4'h0, 64'h0,               4'h0, 4'h0, 1'b0, 16'd0};

        for (int i = 0; i < 9; i++)
            step(tv[i].rst, tv[i].rq, tv[i].ld, tv[i].g, tv[i].d, tv[i].b, tv[i].c,
                 $sformatf("vec%0d", i));

        // Round robin, all loads 1; owner drops req during its DONE cycle.
        do_reset();
        load_val = ldv(16'd1, 16'd1, 16'd1, 16'd1);
        req = 4'hF;
        gq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        watch("rr", 60, 1'b1);

        // Two requesters held continuously must alternate.
        do_reset();
        load_val = ldv(16'd2, 16'd2, 0, 0);
        req = 4'h3;
        gq = '{4'h1, 4'h2, 4'h1};
        watch("prio", 60, 1'b0);

        // Abandon at count 8; pending req[3] is granted next.
        do_reset();
        load_val = ldv(0, 16'h0010, 0, 16'd5);
        req = 4'hA;
        wait_count(16'd8, "abandon.wait");
        step(1'b1, 4'h8, load_val, 4'h0, 4'h0, 1'b0, 16'd0, "abandon.idle");
        step(1'b1, 4'h8, load_val, 4'h8, 4'h0, 1'b1, 16'd5, "abandon.regrant");

        // Reset in the middle of a long count.
        do_reset();
        load_val = ldv(16'hFFFF, 0, 0, 0);
        req = 4'h1;
        wait_count(16'hFFF0, "rstmid.wait");
        step(1'b0, 4'h1, load_val, 4'h0, 4'h0, 1'b0, 16'd0,    "rstmid.reset");
        step(1'b1, 4'h1, load_val, 4'h1, 4'h0, 1'b1, 16'hFFFF, "rstmid.regrant");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
